// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants and the window-compare helper for the
//                multi-channel PWM generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    // Counting modes, sampled at each period boundary.
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    // Timebase counting direction (only centre mode ever counts down).
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // High-window test on a [start,end) window. Arguments are zero-extended by
    // the caller so one function serves any counter width up to 32 bits.
    // start==end is always low; start>end wraps through zero.
    function automatic logic window_hit(input logic [31:0] cnt,
                                        input logic [31:0] win_start,
                                        input logic [31:0] win_end);
        logic hit;
        if (win_start == win_end) begin
            hit = 1'b0;
        end else if (win_start < win_end) begin
            hit = (cnt >= win_start) && (cnt < win_end);
        end else begin
            hit = (cnt >= win_start) || (cnt < win_end);
        end
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM channel: pending/active window registers, window
//                compare and registered output. With PWM_DEADTIME_EN defined
//                a complementary output with dead-time insertion is added.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel
    import pwm_pkg::*;
#(
    parameter int N = 8
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DT_W = 6
`endif
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            load,
    input  logic            wr,
    input  logic [N-1:0]    cfg_start,
    input  logic [N-1:0]    cfg_end,
    input  logic [N-1:0]    cnt,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_out_n,
`endif
    output logic            pwm_out
);

    logic [N-1:0] r_pend_start;
    logic [N-1:0] r_pend_end;
    logic [N-1:0] r_act_start;
    logic [N-1:0] r_act_end;
    logic         w_raw;

    // Pending window registers: written by the config bus at any time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_start <= '0;
            r_pend_end   <= '0;
        end else if (wr) begin
            r_pend_start <= cfg_start;
            r_pend_end   <= cfg_end;
        end
    end

    // Active window registers: copied from pending only when the top says so
    // (period boundary or while disabled), so a period never sees a torn window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_act_start <= '0;
            r_act_end   <= '0;
        end else if (load) begin
            r_act_start <= r_pend_start;
            r_act_end   <= r_pend_end;
        end
    end

    assign w_raw = enable && window_hit(32'(cnt), 32'(r_act_start), 32'(r_act_end));

`ifdef PWM_DEADTIME_EN
    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    logic [0:0]      r_state;
    logic [DT_W-1:0] r_dt_cnt;
    logic            r_raw_prev;
    logic            r_out;
    logic            r_out_n;

    // Dead-time FSM: every raw edge blanks both outputs for dead_time clocks
    // (restarting on a further edge), then the new level and its complement
    // are driven.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_PASS;
            r_dt_cnt   <= '0;
            r_raw_prev <= 1'b0;
            r_out      <= 1'b0;
            r_out_n    <= 1'b0;
        end else if (!enable) begin
            r_state    <= ST_PASS;
            r_dt_cnt   <= '0;
            r_raw_prev <= 1'b0;
            r_out      <= 1'b0;
            r_out_n    <= 1'b0;
        end else begin
            r_raw_prev <= w_raw;
            if ((w_raw != r_raw_prev) && (dead_time != '0)) begin
                r_state  <= ST_DEAD;
                r_dt_cnt <= dead_time - DT_W'(1);
                r_out    <= 1'b0;
                r_out_n  <= 1'b0;
            end else if ((r_state == ST_DEAD) && (r_dt_cnt != '0)) begin
                r_dt_cnt <= r_dt_cnt - DT_W'(1);
            end else begin
                r_state <= ST_PASS;
                r_out   <= w_raw;
                r_out_n <= ~w_raw;
            end
        end
    end

    assign pwm_out   = r_out;
    assign pwm_out_n = r_out_n;
`else
    logic r_out;

    // Registered output: one clock of latency from the counter value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_raw;
        end
    end

    assign pwm_out = r_out;
`endif

endmodule

`default_nettype wire

// File: rtl/pwm_multi.sv
// ============================================================================
//  Module      : pwm_multi
//  Description : Multi-channel PWM generator with a shared prescaled
//                timebase (edge- or centre-aligned) and double-buffered
//                per-channel [start,end) windows. Defining PWM_DEADTIME_EN
//                adds dead_time / pwm_out_n and dead-time insertion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N    = 8,
    parameter int CH   = 4,
    parameter int PS_W = 8
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DT_W = 6
`endif
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                mode,
    input  logic [N-1:0]                        period,
    input  logic [PS_W-1:0]                     prescale,
    input  logic                                cfg_wr,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
    input  logic [N-1:0]                        cfg_start,
    input  logic [N-1:0]                        cfg_end,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]                     dead_time,
    output logic [CH-1:0]                       pwm_out_n,
`endif
    output logic [CH-1:0]                       pwm_out,
    output logic                                period_done,
    output logic                                upd_pending
);

    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic [PS_W-1:0] r_ps_cnt;
    logic [PS_W-1:0] r_act_prescale;
    logic [N-1:0]    r_act_period;
    logic            r_act_mode;
    logic [N-1:0]    r_cnt;
    logic            r_dir;
    logic            r_period_done;
    logic            r_upd_pending;

    logic            w_tick;
    logic            w_boundary;
    logic            w_load;
    logic            w_wr_valid;
    logic [N-1:0]    w_cnt_inc;

    assign w_tick    = enable && (r_ps_cnt == r_act_prescale);
    assign w_cnt_inc = r_cnt + N'(1);

    // Edge mode ends a period on the top value; centre mode ends it on the
    // last down step (1 -> 0), or on every tick when the period is zero.
    assign w_boundary = (r_act_mode == MODE_CENTRE)
                      ? (w_tick && (((r_dir == DIR_DOWN) && (r_cnt == N'(1))) ||
                                    ((r_act_period == '0) && (r_cnt == '0))))
                      : (w_tick && (r_cnt == r_act_period));

    // Active registers follow pending continuously while disabled.
    assign w_load     = !enable || w_boundary;
    assign w_wr_valid = cfg_wr && (32'(cfg_ch) < 32'(CH));

    // Prescaler and timebase counter. Every boundary restarts at 0 counting
    // up, which also covers a mode change between periods.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ps_cnt <= '0;
            r_cnt    <= '0;
            r_dir    <= DIR_UP;
        end else if (!enable) begin
            r_ps_cnt <= '0;
            r_cnt    <= '0;
            r_dir    <= DIR_UP;
        end else begin
            r_ps_cnt <= w_tick ? '0 : (r_ps_cnt + PS_W'(1));
            if (w_boundary) begin
                r_cnt <= '0;
                r_dir <= DIR_UP;
            end else if (w_tick) begin
                if (r_act_mode == MODE_EDGE) begin
                    r_cnt <= w_cnt_inc;
                end else if (r_dir == DIR_UP) begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == r_act_period) begin
                        r_dir <= DIR_DOWN;
                    end
                end else begin
                    r_cnt <= r_cnt - N'(1);
                end
            end
        end
    end

    // Timebase configuration: sampled from the inputs at load time only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_act_period   <= '0;
            r_act_prescale <= '0;
            r_act_mode     <= MODE_EDGE;
        end else if (w_load) begin
            r_act_period   <= period;
            r_act_prescale <= prescale;
            r_act_mode     <= mode;
        end
    end

    // Status flags: boundary pulse and "pending not yet transferred". A write
    // coinciding with a boundary keeps the flag set for the next period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_period_done <= 1'b0;
            r_upd_pending <= 1'b0;
        end else begin
            r_period_done <= w_boundary;
            if (!enable) begin
                r_upd_pending <= w_wr_valid;
            end else if (w_wr_valid) begin
                r_upd_pending <= 1'b1;
            end else if (w_boundary) begin
                r_upd_pending <= 1'b0;
            end
        end
    end

    assign period_done = r_period_done;
    assign upd_pending = r_upd_pending;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            pwm_channel #(
                .N    (N)
`ifdef PWM_DEADTIME_EN
                ,
                .DT_W (DT_W)
`endif
            ) u_channel (
                .clock     (clock),
                .reset     (reset),
                .enable    (enable),
                .load      (w_load),
                .wr        (w_wr_valid && (cfg_ch == CH_W'(gi))),
                .cfg_start (cfg_start),
                .cfg_end   (cfg_end),
                .cnt       (r_cnt),
`ifdef PWM_DEADTIME_EN
                .dead_time (dead_time),
                .pwm_out_n (pwm_out_n[gi]),
`endif
                .pwm_out   (pwm_out[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
// ============================================================================
//  Module      : tb_pwm_multi
//  Description : Directed self-checking bench for pwm_multi (N=8, CH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_multi;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       mode;
    logic [7:0] period;
    logic [7:0] prescale;
    logic       cfg_wr;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_start;
    logic [7:0] cfg_end;
    logic [3:0] pwm_out;
    logic       period_done;
    logic       upd_pending;
`ifdef PWM_DEADTIME_EN
    logic [5:0] dead_time;
    logic [3:0] pwm_out_n;
`endif

    int tests = 0;
    int fails = 0;

    pwm_multi #(.N(8), .CH(4), .PS_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .period      (period),
        .prescale    (prescale),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_start   (cfg_start),
        .cfg_end     (cfg_end),
`ifdef PWM_DEADTIME_EN
        .dead_time   (dead_time),
        .pwm_out_n   (pwm_out_n),
`endif
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .upd_pending (upd_pending)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-clock write strobe, issued at a negedge and captured on the next posedge.
    task automatic write_cfg(input logic [1:0] ch, input logic [7:0] s, input logic [7:0] e);
        cfg_wr    = 1'b1;
        cfg_ch    = ch;
        cfg_start = s;
        cfg_end   = e;
        @(negedge clock);
        cfg_wr    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        mode      = 1'b0;
        period    = 8'd0;
        prescale  = 8'd0;
        cfg_wr    = 1'b0;
        cfg_ch    = 2'd0;
        cfg_start = 8'd0;
        cfg_end   = 8'd0;
`ifdef PWM_DEADTIME_EN
        dead_time = 6'd0;
`endif
        repeat (2) @(negedge clock);

        // Reset state
        chk("reset pwm_out", 32'(pwm_out), 32'h0);
        chk("reset period_done", 32'(period_done), 32'h0);
        chk("reset upd_pending", 32'(upd_pending), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // 1: edge mode, period 9, ch0 [2,5)
        period = 8'd9;
        write_cfg(2'd0, 8'd2, 8'd5);
        chk("t1 upd while disabled", 32'(upd_pending), 32'h1);
        @(negedge clock);
        chk("t1 upd clears disabled", 32'(upd_pending), 32'h0);
        enable = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clock);
            chk($sformatf("t1 pwm0 j=%0d", j), 32'(pwm_out[0]), 32'((j % 10) >= 2 && (j % 10) <= 4));
            chk($sformatf("t1 done j=%0d", j), 32'(period_done), 32'((j % 10) == 9));
        end

        // 2: centre mode, period 4, ch1 [2,5): cnt 0,1,2,3,4,3,2,1
        enable = 1'b0;
        mode   = 1'b1;
        period = 8'd4;
        write_cfg(2'd1, 8'd2, 8'd5);
        @(negedge clock);
        chk("t2 disabled pwm", 32'(pwm_out), 32'h0);
        enable = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            chk($sformatf("t2 pwm1 j=%0d", j), 32'(pwm_out[1]), 32'((j % 8) >= 2 && (j % 8) <= 6));
            chk($sformatf("t2 done j=%0d", j), 32'(period_done), 32'((j % 8) == 7));
        end

        // 3: double buffering, mid-period write and write in the boundary clock
        enable = 1'b0;
        mode   = 1'b0;
        period = 8'd9;
        @(negedge clock);
        enable = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            chk($sformatf("t3 pwm0 j=%0d", j), 32'(pwm_out[0]),
                32'((j < 10) ? ((j % 10) >= 2 && (j % 10) <= 4) :
                    (j < 30) ? ((j % 10) == 5 || (j % 10) == 6) : 1'b1));
            chk($sformatf("t3 upd j=%0d", j), 32'(upd_pending),
                32'((j >= 4 && j <= 8) || (j >= 19 && j <= 28)));
            chk($sformatf("t3 done j=%0d", j), 32'(period_done), 32'((j % 10) == 9));
            if (j == 3) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_start = 8'd5; cfg_end = 8'd7;
            end else if (j == 18) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_start = 8'd0; cfg_end = 8'd10;
            end else begin
                cfg_wr = 1'b0;
            end
        end

        // 4: wrap window on ch2, start==end on ch3, full-on ch0
        enable = 1'b0;
        write_cfg(2'd2, 8'd8, 8'd2);
        write_cfg(2'd3, 8'd3, 8'd3);
        @(negedge clock);
        enable = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            chk($sformatf("t4 pwm2 j=%0d", j), 32'(pwm_out[2]), 32'((j % 10) >= 8 || (j % 10) < 2));
            chk($sformatf("t4 pwm3 j=%0d", j), 32'(pwm_out[3]), 32'h0);
            chk($sformatf("t4 pwm0 j=%0d", j), 32'(pwm_out[0]), 32'h1);
        end

        // 5: prescale 2, enable drop mid-period, re-enable, async reset
        enable   = 1'b0;
        prescale = 8'd2;
        write_cfg(2'd0, 8'd2, 8'd5);
        @(negedge clock);
        enable = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            chk($sformatf("t5 pwm0 j=%0d", j), 32'(pwm_out[0]), 32'((j / 3) >= 2 && (j / 3) <= 4));
            chk($sformatf("t5 done j=%0d", j), 32'(period_done), 32'h0);
        end
        enable = 1'b0;
        @(negedge clock);
        chk("t5 disable pwm", 32'(pwm_out), 32'h0);
        chk("t5 disable done", 32'(period_done), 32'h0);
        enable = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clock);
            chk($sformatf("t5 re-enable pwm0 j=%0d", j), 32'(pwm_out[0]), 32'(j >= 6));
        end
        reset = 1'b1;
        #1;
        chk("t5 async reset pwm", 32'(pwm_out), 32'h0);
        chk("t5 async reset done", 32'(period_done), 32'h0);
        chk("t5 async reset upd", 32'(upd_pending), 32'h0);
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b0;

        // period 0: every tick is a boundary, counter stuck at 0
        prescale = 8'd0;
        period   = 8'd0;
        write_cfg(2'd0, 8'd0, 8'd1);
        @(negedge clock);
        enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            chk($sformatf("p0 done j=%0d", j), 32'(period_done), 32'h1);
            chk($sformatf("p0 pwm0 j=%0d", j), 32'(pwm_out[0]), 32'h1);
        end

`ifdef PWM_DEADTIME_EN
        // 6: dead-time 3, ch0 [2,8) period 9
        begin
            int hi_p;
            int hi_n;
            hi_p   = 0;
            hi_n   = 0;
            enable = 1'b0;
            period = 8'd9;
            dead_time = 6'd3;
            write_cfg(2'd0, 8'd2, 8'd8);
            @(negedge clock);
            enable = 1'b1;
            for (int j = 0; j < 30; j++) begin
                @(negedge clock);
                chk($sformatf("t6 overlap j=%0d", j), 32'(pwm_out[0] && pwm_out_n[0]), 32'h0);
                if (j >= 10 && j < 20) begin
                    hi_p += int'(pwm_out[0]);
                    hi_n += int'(pwm_out_n[0]);
                end
            end
            chk("t6 pwm high clocks", 32'(hi_p), 32'd3);
            chk("t6 pwm_n high clocks", 32'(hi_n), 32'd1);
            enable = 1'b0;
            @(negedge clock);
            chk("t6 disable both low", 32'({pwm_out, pwm_out_n}), 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
